// File: rtl/tt_pwm_multi.sv
// -----------------------------------------------------------------------------
// tt_pwm_multi -- multi-channel PWM generator for a Tiny Tapeout tile.
//
// A shared prescaler and period counter feed CHANNELS comparators. Every
// setting lives in a shadow register written through a byte-wide port. The
// shadow copies into the active register only at period wrap, so an output
// never changes shape part-way through a period.
//
// Optional feature macro: PWM_POL_EN
//   defined   : POL register at address CHANNELS+2; bit i inverts pwm_out[i].
//               POL is double-buffered like the duty registers.
//   undefined : no POL register and no inversion logic. Writes to
//               CHANNELS+2 are ignored.
//
// Ports
//   clk          tile clock
//   rst          synchronous reset, active-high
//   ena          count enable; 0 freezes prescaler, counter and outputs
//   wr_en        register write strobe
//   wr_addr      0=PERIOD, 1=PRESCALE, 2..CHANNELS+1=DUTY[i], CHANNELS+2=POL
//   wr_data      write data (PRESCALE takes the low 8 bits)
//   pwm_out      registered PWM outputs, 1 cycle behind the counter
//   period_tick  one-cycle pulse on each period wrap
// -----------------------------------------------------------------------------
module tt_pwm_multi #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8,
    parameter int AW       = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [WIDTH-1:0]    wr_data,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_tick
);

    localparam logic [AW-1:0] ADDR_PERIOD   = AW'(0);
    localparam logic [AW-1:0] ADDR_PRESCALE = AW'(1);

    logic [WIDTH-1:0]    r_period_sh;
    logic [WIDTH-1:0]    r_period_act;
    logic [7:0]          r_prescale_sh;
    logic [7:0]          r_prescale_act;
    logic [7:0]          r_pre_cnt;
    logic [WIDTH-1:0]    r_cnt;
    logic [CHANNELS-1:0] r_pwm;
    logic                r_tick;

    logic [7:0]          w_wr_lo8;
    logic                w_step;
    logic                w_wrap;
    logic [CHANNELS-1:0] w_cmp;
    logic [CHANNELS-1:0] w_pwm_next;

    assign w_wr_lo8 = 8'(wr_data);
    assign w_step   = (r_pre_cnt == r_prescale_act);
    // Wrap is the single event that advances the period and loads every
    // active register. It is gated by ena, so a frozen tile never reloads.
    assign w_wrap   = ena && w_step && (r_cnt == r_period_act);

    // Shared timebase: prescaler, period counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_period_sh    <= '1;
            r_period_act   <= '1;
            r_prescale_sh  <= '0;
            r_prescale_act <= '0;
            r_pre_cnt      <= '0;
            r_cnt          <= '0;
            r_pwm          <= '0;
            r_tick         <= 1'b0;
        end else begin
            if (wr_en && wr_addr == ADDR_PERIOD) begin
                r_period_sh <= wr_data;
            end
            if (wr_en && wr_addr == ADDR_PRESCALE) begin
                r_prescale_sh <= w_wr_lo8;
            end

            r_tick <= w_wrap;

            if (ena) begin
                r_pre_cnt <= w_step ? 8'd0 : r_pre_cnt + 8'd1;
                if (w_step) begin
                    r_cnt <= (r_cnt == r_period_act) ? '0 : r_cnt + WIDTH'(1);
                end
                // On the wrap cycle the active registers take the shadow's
                // value from before this edge. A write on the same cycle
                // stays in the shadow until the next wrap.
                if (w_wrap) begin
                    r_period_act   <= r_period_sh;
                    r_prescale_act <= r_prescale_sh;
                end
                r_pwm <= w_pwm_next;
            end
        end
    end

    // Per-channel duty registers and comparators.
    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [WIDTH-1:0] r_duty_sh;
            logic [WIDTH-1:0] r_duty_act;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_duty_sh  <= '0;
                    r_duty_act <= '0;
                end else begin
                    if (w_wrap) begin
                        r_duty_act <= r_duty_sh;
                    end
                    if (wr_en && wr_addr == AW'(gi + 2)) begin
                        r_duty_sh <= wr_data;
                    end
                end
            end

            // The counter never exceeds the period. So duty=0 gives a
            // constant 0, and duty > period gives a constant 1.
            assign w_cmp[gi] = (r_cnt < r_duty_act);
        end
    endgenerate

`ifdef PWM_POL_EN
    logic [CHANNELS-1:0] r_pol_sh;
    logic [CHANNELS-1:0] r_pol_act;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pol_sh  <= '0;
            r_pol_act <= '0;
        end else begin
            if (w_wrap) begin
                r_pol_act <= r_pol_sh;
            end
            if (wr_en && wr_addr == AW'(CHANNELS + 2)) begin
                r_pol_sh <= CHANNELS'(wr_data);
            end
        end
    end

    // Polarity is applied before the output register. Reset still
    // clears pwm_out to 0 whatever the polarity is.
    assign w_pwm_next = w_cmp ^ r_pol_act;
`else
    assign w_pwm_next = w_cmp;
`endif

    assign pwm_out     = r_pwm;
    assign period_tick = r_tick;

endmodule

// File: tb/tb_tt_pwm_multi.sv
// -----------------------------------------------------------------------------
// tb_tt_pwm_multi -- self-checking bench for tt_pwm_multi (CHANNELS=4,
// WIDTH=8, AW=3).
//
// The reference model tracks the clock index inside the current period. The
// counter value is that index divided by (prescale+1). A wrap happens on the
// last clock of a period, whose length is (period+1)*(prescale+1).
// Define PWM_POL_EN for both files together to check the polarity option.
// -----------------------------------------------------------------------------
module tb_tt_pwm_multi;

    localparam int CH = 4;

    logic          clk;
    logic          rst;
    logic          ena;
    logic          wr_en;
    logic [2:0]    wr_addr;
    logic [7:0]    wr_data;
    logic [CH-1:0] pwm_out;
    logic          period_tick;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state.
    int            m_per_s, m_per_a, m_pre_s, m_pre_a, m_pol_s, m_pol_a;
    int            m_duty_s [CH];
    int            m_duty_a [CH];
    int            m_t;
    logic [CH-1:0] m_pwm;
    logic          m_tick;

    tt_pwm_multi #(.CHANNELS(CH), .WIDTH(8), .AW(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .pwm_out     (pwm_out),
        .period_tick (period_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int period_len();
        return (m_per_a + 1) * (m_pre_a + 1);
    endfunction

    // Model of one rising edge, driven by the inputs for that edge.
    task automatic model_edge(input logic r, input logic e, input logic w,
                              input int a, input int d);
        int cur;
        if (r) begin
            m_per_s = 255; m_per_a = 255; m_pre_s = 0; m_pre_a = 0;
            m_pol_s = 0;   m_pol_a = 0;   m_t = 0;
            for (int i = 0; i < CH; i++) begin
                m_duty_s[i] = 0;
                m_duty_a[i] = 0;
            end
            m_pwm  = '0;
            m_tick = 1'b0;
            return;
        end
        if (e) begin
            cur = m_t / (m_pre_a + 1);
            for (int i = 0; i < CH; i++)
                m_pwm[i] = (cur < m_duty_a[i]) ^ (((m_pol_a >> i) & 1) == 1);
            m_tick = (m_t == period_len() - 1);
            if (m_tick) begin
                m_t     = 0;
                m_per_a = m_per_s;
                m_pre_a = m_pre_s;
                m_pol_a = m_pol_s;
                for (int i = 0; i < CH; i++) m_duty_a[i] = m_duty_s[i];
            end else begin
                m_t++;
            end
        end else begin
            m_tick = 1'b0;
        end
        // The write lands in the shadow after any wrap load on the same edge.
        if (w) begin
            if (a == 0) m_per_s = d & 255;
            else if (a == 1) m_pre_s = d & 255;
            else if (a >= 2 && a < CH + 2) m_duty_s[a - 2] = d & 255;
`ifdef PWM_POL_EN
            else if (a == CH + 2) m_pol_s = d & ((1 << CH) - 1);
`endif
        end
    endtask

    // One clock: drive the inputs, step the model at the edge, check on negedge.
    task automatic cyc(input logic r, input logic e, input logic w,
                       input int a, input int d);
        rst     = r;
        ena     = e;
        wr_en   = w;
        wr_addr = 3'(a);
        wr_data = 8'(d);
        if (w) $display("wr addr=%0d data=%0d rst=%0b ena=%0b t=%0t", a, d & 255, r, e, $time);
        @(posedge clk);
        model_edge(r, e, w, a, d);
        @(negedge clk);
        chk("pwm_out", 32'(pwm_out), 32'(m_pwm));
        chk("period_tick", 32'(period_tick), 32'(m_tick));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, 0, 0);
    endtask

    task automatic wr(input int a, input int d);
        cyc(1'b0, 1'b1, 1'b1, a, d);
    endtask

    // Advance until the next edge is a wrap edge.
    task automatic run_to_wrap_edge();
        int n;
        n = 0;
        while (m_t != period_len() - 1 && n < 2000) begin
            idle(1);
            n++;
        end
        chk("wrap_wait_timeout", 32'(n < 2000), 32'd1);
    endtask

    initial begin
        int ticks;
        int a;
        int d;
        logic r;
        logic e;
        logic w;

        rst = 1'b1; ena = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        m_t = 0; m_pwm = '0; m_tick = 1'b0;
        @(negedge clk);

        // 1. Reset for two cycles, then default registers give a 256-cycle period.
        cyc(1'b1, 1'b0, 1'b0, 0, 0);
        cyc(1'b1, 1'b0, 1'b0, 0, 0);
        chk("reset_pwm", 32'(pwm_out), 32'd0);
        chk("reset_tick", 32'(period_tick), 32'd0);
        ticks = 0;
        for (int i = 0; i < 512; i++) begin
            idle(1);
            if (period_tick) ticks++;
        end
        chk("default_ticks_512", 32'(ticks), 32'd2);

        // 2. PERIOD=3, DUTY0=2: expect 1,1,0,0 after one wrap.
        wr(0, 3);
        wr(2, 2);
        run_to_wrap_edge();
        idle(1);
        idle(24);

        // 3. Prescale 2, plus constant-0 and constant-1 duties.
        wr(1, 2);
        wr(3, 1);
        wr(4, 0);
        wr(5, 9);
        idle(40);

        // 4. Mid-period duty change takes effect only at the next wrap.
        idle(4);
        wr(2, 3);
        idle(30);

        // 5. Write on the wrap edge applies one period later.
        wr(1, 0);
        idle(30);
        run_to_wrap_edge();
        wr(2, 1);
        idle(12);
        // ena low for five cycles, then resume.
        idle(2);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 0, 0);
        idle(10);
        // Reset mid-period.
        idle(1);
        cyc(1'b1, 1'b1, 1'b0, 0, 0);
        chk("midrst_pwm", 32'(pwm_out), 32'd0);
        idle(3);

        // 6. Polarity: POL=1 with DUTY0=1 (ignored when the option is absent).
        wr(0, 3);
        wr(2, 1);
        wr(CH + 2, 1);
        idle(20);
        wr(7, 0);    // unmapped address
        idle(10);

        // Random phase.
        for (int k = 0; k < 3000; k++) begin
            r = ($urandom_range(0, 199) == 0);
            e = ($urandom_range(0, 9) != 0);
            w = ($urandom_range(0, 4) == 0);
            a = $urandom_range(0, 7);
            if (a == 0) d = $urandom_range(0, 7);
            else if (a == 1) d = $urandom_range(0, 3);
            else if ($urandom_range(0, 19) == 0) d = $urandom_range(0, 255);
            else d = $urandom_range(0, 10);
            cyc(r, e, w, a, d);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
